// File: rtl/uart_pkg.sv
// Shared UART types and helpers. The PARITY state and parity bit count exist only
// when UART_TX_PARITY_EN is defined.
package uart_pkg;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam int PARITY_BITS = 1;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } uart_state_t;

  localparam int PARITY_BITS = 0;
`endif

  // Bit-times in one frame: start + data + optional parity + stop.
  function automatic int frame_bits(input int data_bits, input int stop_bits, input int parity_bits);
    return 1 + data_bits + parity_bits + stop_bits;
  endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Producer-to-transmitter word handshake (valid/ready plus data word).
interface uart_tx_frame_if #(
  parameter int DATA_BITS = 8
);
  logic                 tx_valid;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_ready;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_baud_tick.sv
// Clocks-per-bit divider: tick is high in the last cycle of every bit period.
// Shared with the UART receiver.
module uart_baud_tick #(
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = (count == LAST);
endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: one word per valid/ready transfer, sent start/data(LSB first)/parity/stop.
// Define UART_TX_PARITY_EN to insert a parity bit (even, or odd with PARITY_ODD=1).
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_frame_if.slave   tx_if,
  output logic             txd,
  output logic             busy
);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  if (CLK_DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
      (STOP_BITS != 1 && STOP_BITS != 2) || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
    $error("uart_tx_frame: illegal parameter value");
  end

  uart_state_t          state;
  logic [DATA_BITS-1:0] shreg;
  logic [3:0]           bit_cnt;
  logic                 tick;
  logic                 accept;
`ifdef UART_TX_PARITY_EN
  logic                 parity_bit;
`endif

  assign accept = tx_if.tx_valid && tx_if.tx_ready;

  // Divider is held clear while idle so START always gets a full bit period.
  uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (state == IDLE),
    .tick  (tick)
  );

  // txd is registered one bit ahead: each transition edge loads the level of the next bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      shreg          <= '0;
      bit_cnt        <= '0;
      txd            <= 1'b1;
      tx_if.tx_ready <= 1'b1;
      busy           <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shreg          <= tx_if.tx_data;
            bit_cnt        <= '0;
            txd            <= 1'b0;
            tx_if.tx_ready <= 1'b0;
            busy           <= 1'b1;
            state          <= START;
`ifdef UART_TX_PARITY_EN
            parity_bit     <= (^tx_if.tx_data) ^ PARITY_ODD[0];
`endif
          end
        end
        START: begin
          if (tick) begin
            txd   <= shreg[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            shreg <= shreg >> 1;
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
              txd     <= parity_bit;
              state   <= PARITY;
`else
              txd     <= 1'b1;
              state   <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
              txd     <= shreg[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            txd   <= 1'b1;
            state <= STOP;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (bit_cnt == LAST_STOP) begin
              bit_cnt        <= '0;
              tx_if.tx_ready <= 1'b1;
              busy           <= 1'b0;
              state          <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        default: begin
          txd            <= 1'b1;
          tx_if.tx_ready <= 1'b1;
          busy           <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: two configurations (8-bit/1-stop/even and 7-bit/2-stop/odd)
// against a frame-level model; build with and without UART_TX_PARITY_EN.
module tb_uart_tx_frame;
  import uart_pkg::*;

  localparam int C0 = 4, D0 = 8, S0 = 1, O0 = 0;
  localparam int C1 = 3, D1 = 7, S1 = 2, O1 = 1;
  localparam int HN = 8192;

`ifdef UART_TX_PARITY_EN
  localparam int          RDY0  = 45;
  localparam int          RDY1  = 34;
  localparam logic [10:0] EXP55 = 11'b10010101010;
  localparam int          PAR0  = 1;
  localparam int          PAR1  = 0;
  localparam int          STOPK = 9;
`else
  localparam int          RDY0  = 41;
  localparam int          RDY1  = 31;
  localparam logic [10:0] EXP55 = 11'b11010101010;
  localparam int          PAR0  = 1;
  localparam int          PAR1  = 1;
  localparam int          STOPK = 8;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       v [2];
  logic [8:0] d [2];
  logic       txd0, txd1, busy0, busy1;
  logic       chk_en = 1'b0;

  uart_tx_frame_if #(.DATA_BITS(D0)) if0 ();
  uart_tx_frame_if #(.DATA_BITS(D1)) if1 ();

  assign if0.tx_valid = v[0];
  assign if0.tx_data  = d[0][7:0];
  assign if1.tx_valid = v[1];
  assign if1.tx_data  = d[1][6:0];

  uart_tx_frame #(.CLK_DIV(C0), .DATA_BITS(D0), .STOP_BITS(S0), .PARITY_ODD(O0)) dut0 (
    .clk(clk), .rst(rst), .tx_if(if0), .txd(txd0), .busy(busy0));
  uart_tx_frame #(.CLK_DIV(C1), .DATA_BITS(D1), .STOP_BITS(S1), .PARITY_ODD(O1)) dut1 (
    .clk(clk), .rst(rst), .tx_if(if1), .txd(txd1), .busy(busy1));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Frame model: expected waveform is a bit list, each bit held for CLK_DIV cycles.
  int          m_pos   [2] = '{-1, -1};
  int          m_len   [2] = '{0, 0};
  logic [15:0] m_frame [2];
  int          acc_cnt [2] = '{0, 0};
  int          acc_cyc [2] = '{0, 0};
  logic        acc_flag[2] = '{1'b0, 1'b0};

  logic hist_txd [2][HN];
  logic hist_rdy [2][HN];
  logic hist_busy[2][HN];

  function automatic int cdiv(input int i);  return (i == 0) ? C0 : C1; endfunction
  function automatic int dbits(input int i); return (i == 0) ? D0 : D1; endfunction
  function automatic int sbits(input int i); return (i == 0) ? S0 : S1; endfunction
  function automatic int oddp(input int i);  return (i == 0) ? O0 : O1; endfunction

  function automatic logic [15:0] make_frame(input logic [8:0] word, input int db, input int odd);
    logic [15:0] f = '1;
    int ones = 0;
    int k = 1;
    f[0] = 1'b0;
    for (int j = 0; j < db; j++) begin
      f[k] = word[j];
      if (word[j]) ones++;
      k++;
    end
    if (PARITY_BITS == 1) f[k] = ((ones + odd) % 2) == 1;
    return f;
  endfunction

  function automatic logic exp_txd(input int i);
    if (m_pos[i] < 0) return 1'b1;
    return m_frame[i][m_pos[i] / cdiv(i)];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic failNow(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  // Model advances on the same edge the DUT samples its inputs.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      acc_flag[i] = 1'b0;
      if (rst) begin
        m_pos[i] = -1;
      end else if (m_pos[i] < 0) begin
        if (v[i]) begin
          m_frame[i]  = make_frame(d[i], dbits(i), oddp(i));
          m_len[i]    = frame_bits(dbits(i), sbits(i), PARITY_BITS) * cdiv(i);
          m_pos[i]    = 0;
          acc_cnt[i]++;
          acc_cyc[i]  = cyc;
          acc_flag[i] = 1'b1;
        end
      end else begin
        m_pos[i]++;
        if (m_pos[i] >= m_len[i]) m_pos[i] = -1;
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (cyc < HN) begin
      hist_txd[0][cyc] = txd0;  hist_rdy[0][cyc] = if0.tx_ready; hist_busy[0][cyc] = busy0;
      hist_txd[1][cyc] = txd1;  hist_rdy[1][cyc] = if1.tx_ready; hist_busy[1][cyc] = busy1;
    end
    if (chk_en) begin
      checkOutput("txd0",  txd0,         exp_txd(0));
      checkOutput("rdy0",  if0.tx_ready, m_pos[0] < 0);
      checkOutput("busy0", busy0,        m_pos[0] >= 0);
      checkOutput("txd1",  txd1,         exp_txd(1));
      checkOutput("rdy1",  if1.tx_ready, m_pos[1] < 0);
      checkOutput("busy1", busy1,        m_pos[1] >= 0);
    end
  end

  task automatic waitAccept(input int i, input int target);
    int t = 0;
    while (acc_cnt[i] < target && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (acc_cnt[i] < target) failNow("accept_timeout");
  endtask

  task automatic applyStimulus(input int i, input logic [8:0] w);
    int base;
    @(negedge clk);
    base = acc_cnt[i];
    v[i] = 1'b1;
    d[i] = w;
    waitAccept(i, base + 1);
    v[i] = 1'b0;
    d[i] = 9'($urandom);
  endtask

  task automatic waitIdle(input int i);
    int t = 0;
    while (m_pos[i] >= 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (m_pos[i] >= 0) failNow("idle_timeout");
    repeat (6) @(negedge clk);
  endtask

  function automatic logic [7:0] decode0(input int n);
    logic [7:0] w;
    for (int j = 0; j < 8; j++) w[j] = hist_txd[0][n + 7 + 4 * j];
    return w;
  endfunction

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n, n1, n2, base;
    logic [10:0] got;
    v[0] = 1'b0; v[1] = 1'b0; d[0] = '0; d[1] = '0;

    // Reset held for three cycles, then a long idle stretch.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_txd",  txd0,         1);
    checkOutput("reset_rdy",  if0.tx_ready, 1);
    checkOutput("reset_busy", busy0,        0);
    rst = 1'b0;
    chk_en = 1'b1;
    repeat (100) @(negedge clk);
    checkOutput("idle_txd1", txd1,  1);
    checkOutput("idle_busy", busy1, 0);

    // 0x55 on the CLK_DIV=4 channel.
    applyStimulus(0, 9'h055);
    n = acc_cyc[0];
    waitIdle(0);
    for (int k = 0; k < 11; k++) got[k] = hist_txd[0][n + 3 + 4 * k];
    checkOutput("frame_55",      got,                      EXP55);
    checkOutput("accept_cyc",    hist_txd[0][n],           1);
    checkOutput("start_first",   hist_txd[0][n + 1],       0);
    checkOutput("start_last",    hist_txd[0][n + 4],       0);
    checkOutput("rdy_before",    hist_rdy[0][n + RDY0 - 1], 0);
    checkOutput("rdy_rise",      hist_rdy[0][n + RDY0],    1);
    checkOutput("busy_fall",     hist_busy[0][n + RDY0],   0);

    // Back-to-back with valid held; the word changes only after the first accept.
    @(negedge clk);
    base = acc_cnt[0];
    v[0] = 1'b1;
    d[0] = 9'h0A5;
    waitAccept(0, base + 1);
    n1 = acc_cyc[0];
    d[0] = 9'h03C;
    waitAccept(0, base + 2);
    n2 = acc_cyc[0];
    v[0] = 1'b0;
    waitIdle(0);
    checkOutput("b2b_gap_txd",   hist_txd[0][n1 + RDY0],     1);
    checkOutput("b2b_gap_rdy",   hist_rdy[0][n1 + RDY0],     1);
    checkOutput("b2b_start",     hist_txd[0][n1 + RDY0 + 1], 0);
    checkOutput("b2b_word1",     decode0(n1),                8'hA5);
    checkOutput("b2b_word2",     decode0(n1 + RDY0),         8'h3C);
    checkOutput("b2b_acc_gap",   n2 - n1,                    RDY0);

    // Parity on both channels with 0x07.
    applyStimulus(0, 9'h007);
    n1 = acc_cyc[0];
    applyStimulus(1, 9'h007);
    n2 = acc_cyc[1];
    waitIdle(0);
    waitIdle(1);
    checkOutput("par0_bit", hist_txd[0][n1 + 3 + 4 * 9], PAR0);
    checkOutput("par1_bit", hist_txd[1][n2 + 2 + 3 * 8], PAR1);
    checkOutput("par0_len", hist_rdy[0][n1 + RDY0 - 1] == 1'b0 && hist_rdy[0][n1 + RDY0] == 1'b1, 1);

    // 7 data bits, 2 stop bits, 0x7F.
    applyStimulus(1, 9'h07F);
    n = acc_cyc[1];
    waitIdle(1);
    checkOutput("s2_stop_a",     hist_txd[1][n + 2 + 3 * STOPK],       1);
    checkOutput("s2_stop_b",     hist_txd[1][n + 2 + 3 * (STOPK + 1)], 1);
    checkOutput("s2_last_data",  hist_txd[1][n + 2 + 3 * 7],           1);
    checkOutput("s2_busy_hold",  hist_busy[1][n + RDY1 - 1],           1);
    checkOutput("s2_busy_fall",  hist_busy[1][n + RDY1],               0);
    checkOutput("s2_rdy_rise",   hist_rdy[1][n + RDY1],                1);

    // Reset in the middle of data bit 3 of an all-zero word.
    applyStimulus(0, 9'h000);
    repeat (17) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_txd",  txd0,         1);
    checkOutput("abort_rdy",  if0.tx_ready, 1);
    checkOutput("abort_busy", busy0,        0);
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      checkOutput("abort_quiet", txd0, 1);
    end
    applyStimulus(0, 9'h081);
    n = acc_cyc[0];
    waitIdle(0);
    checkOutput("after_abort_word", decode0(n), 8'h81);
    checkOutput("after_abort_start", hist_txd[0][n + 1], 0);

    // Randomised traffic with occasional reset, held valid and data scrambling.
    for (int t = 0; t < 4000; t++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 499) == 0);
      for (int i = 0; i < 2; i++) begin
        if (v[i] && acc_flag[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            d[i] = 9'($urandom);
          end else begin
            v[i] = 1'b0;
            d[i] = 9'($urandom);
          end
        end else if (!v[i]) begin
          d[i] = 9'($urandom);
          if ($urandom_range(0, 7) == 0) v[i] = 1'b1;
        end
      end
    end
    @(negedge clk);
    rst  = 1'b0;
    v[0] = 1'b0;
    v[1] = 1'b0;
    waitIdle(0);
    waitIdle(1);
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
